uart_rx_reader: RTL and testbench



---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_byte_fifo.sv | 52 +++++
 rtl/uart_rx_reader.sv | 158 +++++++++++++++
 tb/tb_uart_rx_reader.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receiver read-side logic.
package uart_pkg;

    localparam int unsigned CNT_W = 16;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } rx_word_t;

    typedef enum logic [1:0] {
        IDLE,
        STROBE,
        WAIT_CLR
    } reader_state_t;

    // Increment by one unless already at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        return (inc && (v != {CNT_W{1'b1}})) ? v + CNT_W'(1) : v;
    endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// First-word fall-through FIFO of received words; head is zero while empty.
module uart_byte_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk16x,
    input  logic                     clr,
    input  logic                     push_i,
    input  rx_word_t                 wdata_i,
    input  logic                     pop_i,
    output rx_word_t                 rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;

    rx_word_t          mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q;
    logic [PW-1:0]     rd_ptr_q;
    logic [LW-1:0]     level_q;
    logic              do_push;
    logic              do_pop;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk16x) begin
        if (clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            level_q <= level_q + LW'(do_push) - LW'(do_pop);
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk16x) begin
        if (!clr && do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/uart_rx_reader.sv
// Drains the UART receiver via the r_ready/rdn handshake into a stream FIFO,
// counting parity/frame errors and flagging a stuck r_ready.
module uart_rx_reader
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned RDN_LOW     = 2,
    parameter int unsigned CLR_TIMEOUT = 32
) (
    input  logic                     clk16x,
    input  logic                     clr,
    input  logic                     r_ready,
    input  logic [7:0]               d_out,
    input  logic                     parity_error,
    input  logic                     frame_error,
    output logic                     rdn,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [7:0]               out_data,
    output logic                     out_perr,
    output logic                     out_ferr,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]         perr_count,
    output logic [CNT_W-1:0]         ferr_count,
    output logic                     hs_fault
);

    localparam int unsigned CNT_MAX = (RDN_LOW > CLR_TIMEOUT) ? RDN_LOW : CLR_TIMEOUT;
    localparam int unsigned TW      = $clog2(CNT_MAX + 1);

    logic [1:0]        rr_sync_q;
    logic [1:0]        pe_sync_q;
    logic [1:0]        fe_sync_q;
    logic              rr_s;
    logic              pe_s;
    logic              fe_s;

    reader_state_t     state_q, state_d;
    logic [TW-1:0]     tmr_q, tmr_d;
    rx_word_t          cap_q, cap_d;
    logic              rdn_q, rdn_d;
    logic              push_q, push_d;
    logic              hs_fault_q, hs_fault_d;
    logic [CNT_W-1:0]  perr_cnt_q, perr_cnt_d;
    logic [CNT_W-1:0]  ferr_cnt_q, ferr_cnt_d;

    rx_word_t          head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;

    assign rr_s = rr_sync_q[1];
    assign pe_s = pe_sync_q[1];
    assign fe_s = fe_sync_q[1];

    always_ff @(posedge clk16x) begin
        if (clr) begin
            rr_sync_q <= '0;
            pe_sync_q <= '0;
            fe_sync_q <= '0;
        end else begin
            rr_sync_q <= {rr_sync_q[0], r_ready};
            pe_sync_q <= {pe_sync_q[0], parity_error};
            fe_sync_q <= {fe_sync_q[0], frame_error};
        end
    end

    always_ff @(posedge clk16x) begin
        if (clr) begin
            state_q    <= IDLE;
            tmr_q      <= '0;
            cap_q      <= '0;
            rdn_q      <= 1'b1;
            push_q     <= 1'b0;
            hs_fault_q <= 1'b0;
            perr_cnt_q <= '0;
            ferr_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            cap_q      <= cap_d;
            rdn_q      <= rdn_d;
            push_q     <= push_d;
            hs_fault_q <= hs_fault_d;
            perr_cnt_q <= perr_cnt_d;
            ferr_cnt_q <= ferr_cnt_d;
        end
    end

    // Handshake sequencing; the full check in IDLE reserves the slot for the capture.
    always_comb begin
        state_d    = state_q;
        tmr_d      = tmr_q;
        cap_d      = cap_q;
        rdn_d      = 1'b1;
        push_d     = 1'b0;
        hs_fault_d = hs_fault_q;
        perr_cnt_d = push_q ? sat_inc(perr_cnt_q, cap_q.perr) : perr_cnt_q;
        ferr_cnt_d = push_q ? sat_inc(ferr_cnt_q, cap_q.ferr) : ferr_cnt_q;
        case (state_q)
            IDLE: begin
                if (rr_s && !fifo_full) begin
                    state_d = STROBE;
                    tmr_d   = '0;
                    cap_d   = '{data: d_out, perr: pe_s, ferr: fe_s};
                    rdn_d   = 1'b0;
                end
            end
            STROBE: begin
                if (tmr_q == TW'(RDN_LOW - 1)) begin
                    state_d = WAIT_CLR;
                    tmr_d   = '0;
                    push_d  = 1'b1;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                    rdn_d = 1'b0;
                end
            end
            WAIT_CLR: begin
                if (!rr_s) begin
                    state_d = IDLE;
                end else if (tmr_q == TW'(CLR_TIMEOUT - 1)) begin
                    hs_fault_d = 1'b1;
                    state_d    = IDLE;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign fifo_pop = out_valid && out_ready;

    uart_byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk16x  (clk16x),
        .clr     (clr),
        .push_i  (push_q),
        .wdata_i (cap_q),
        .pop_i   (fifo_pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    assign rdn        = rdn_q;
    assign out_valid  = !fifo_empty;
    assign out_data   = head.data;
    assign out_perr   = head.perr;
    assign out_ferr   = head.ferr;
    assign perr_count = perr_cnt_q;
    assign ferr_count = ferr_cnt_q;
    assign hs_fault   = hs_fault_q;

endmodule

// File: tb/tb_uart_rx_reader.sv
// Scoreboard bench for uart_rx_reader: a receiver model drives the handshake,
// expected words are queued at stimulus time and checked as the stream pops.
module tb_uart_rx_reader;
    import uart_pkg::*;

    logic        clk16x = 1'b0;
    logic        clr = 1'b1;
    logic        r_ready = 1'b0;
    logic [7:0]  d_out = 8'h00;
    logic        parity_error = 1'b0;
    logic        frame_error = 1'b0;
    logic        rdn;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_data;
    logic        out_perr;
    logic        out_ferr;
    logic [3:0]  fifo_level;
    logic [15:0] perr_count;
    logic [15:0] ferr_count;
    logic        hs_fault;

    rx_word_t exp_q[$];
    rx_word_t mon_w;
    int checks = 0;
    int errors = 0;
    int max_level = 0;
    bit track_level = 1'b0;

    uart_rx_reader #(
        .DEPTH       (8),
        .RDN_LOW     (2),
        .CLR_TIMEOUT (32)
    ) dut (
        .clk16x       (clk16x),
        .clr          (clr),
        .r_ready      (r_ready),
        .d_out        (d_out),
        .parity_error (parity_error),
        .frame_error  (frame_error),
        .rdn          (rdn),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_perr     (out_perr),
        .out_ferr     (out_ferr),
        .fifo_level   (fifo_level),
        .perr_count   (perr_count),
        .ferr_count   (ferr_count),
        .hs_fault     (hs_fault)
    );

    always #5 clk16x = ~clk16x;

    // Stream monitor: every accepted head must match the oldest queued word.
    always @(negedge clk16x) begin
        if (!clr && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pop: got %h/%b/%b expected no word", out_data, out_perr, out_ferr);
            end else begin
                mon_w = exp_q.pop_front();
                if (out_data !== mon_w.data || out_perr !== mon_w.perr || out_ferr !== mon_w.ferr) begin
                    errors++;
                    $display("FAIL pop_word: got %h/%b/%b expected %h/%b/%b",
                             out_data, out_perr, out_ferr, mon_w.data, mon_w.perr, mon_w.ferr);
                end
            end
        end
        if (track_level && int'(fifo_level) > max_level) max_level = int'(fifo_level);
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk16x);
            #1;
        end
    endtask

    task automatic do_reset();
        clr = 1'b1;
        r_ready = 1'b0;
        out_ready = 1'b0;
        tick(2);
        clr = 1'b0;
        exp_q.delete();
        tick(1);
    endtask

    task automatic present(input logic [7:0] d, input logic pe, input logic fe);
        d_out = d;
        parity_error = pe;
        frame_error = fe;
        r_ready = 1'b1;
        exp_q.push_back('{data: d, perr: pe, ferr: fe});
    endtask

    // Receiver side: wait for the strobe, measure it, then withdraw r_ready.
    task automatic finish_read(input string name);
        int n;
        int low;
        n = 0;
        while (rdn === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        if (rdn !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL %s_strobe: rdn stayed 1 for %0d cycles expected a strobe", name, n);
            r_ready = 1'b0;
            return;
        end
        low = 0;
        while (rdn === 1'b0 && low < 20) begin
            tick();
            low++;
        end
        check({name, "_rdn_low"}, low, 2);
        tick(3);
        r_ready = 1'b0;
        tick(4);
    endtask

    task automatic drain(input string name);
        int n;
        out_ready = 1'b1;
        n = 0;
        while ((fifo_level != 0 || exp_q.size() != 0) && n < 200) begin
            tick();
            n++;
        end
        check({name, "_drained"}, int'(fifo_level), 0);
    endtask

    initial begin : stim
        int cyc;
        int lowc;
        int strobes;
        logic [7:0] bytes5 [5];
        bytes5[0] = 8'h11; bytes5[1] = 8'h22; bytes5[2] = 8'h33;
        bytes5[3] = 8'h44; bytes5[4] = 8'h55;

        // Reset state
        tick(3);
        check("rst_rdn", int'(rdn), 1);
        check("rst_valid", int'(out_valid), 0);
        check("rst_data", int'(out_data), 0);
        check("rst_level", int'(fifo_level), 0);
        check("rst_perr_cnt", int'(perr_count), 0);
        check("rst_ferr_cnt", int'(ferr_count), 0);
        check("rst_fault", int'(hs_fault), 0);
        clr = 1'b0;
        tick(2);

        // 1: single byte latency and strobe width
        present(8'hA5, 1'b0, 1'b0);
        cyc = 0;
        lowc = 0;
        while (!out_valid && cyc < 50) begin
            tick();
            cyc++;
            if (rdn === 1'b0) lowc++;
        end
        check("t1_latency", cyc, 6);
        check("t1_rdn_low", lowc, 2);
        check("t1_head_data", int'(out_data), 8'hA5);
        check("t1_head_perr", int'(out_perr), 0);
        check("t1_head_ferr", int'(out_ferr), 0);
        check("t1_level", int'(fifo_level), 1);
        tick(2);
        r_ready = 1'b0;
        tick(5);
        check("t1_level_held", int'(fifo_level), 1);
        drain("t1");

        // 2: backpressure with a full FIFO
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            present(8'(i), 1'b0, 1'b0);
            finish_read("t2");
        end
        check("t2_level_full", int'(fifo_level), 8);
        present(8'h08, 1'b0, 1'b0);
        strobes = 0;
        repeat (20) begin
            tick();
            if (rdn === 1'b0) strobes++;
        end
        check("t2_ninth_held", strobes, 0);
        check("t2_head_data", int'(out_data), 8'h00);
        out_ready = 1'b1;
        finish_read("t2_ninth");
        drain("t2");

        // 3: error flags and counters
        do_reset();
        present(8'h3C, 1'b1, 1'b0);
        finish_read("t3a");
        present(8'hC3, 1'b0, 1'b1);
        finish_read("t3b");
        check("t3_head_perr", int'(out_perr), 1);
        check("t3_head_ferr", int'(out_ferr), 0);
        check("t3_perr_cnt", int'(perr_count), 1);
        check("t3_ferr_cnt", int'(ferr_count), 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t3_head2_data", int'(out_data), 8'hC3);
        check("t3_head2_ferr", int'(out_ferr), 1);
        check("t3_head2_perr", int'(out_perr), 0);
        drain("t3");

        // 4: r_ready never falls -> handshake fault, then a duplicate read
        do_reset();
        out_ready = 1'b1;
        present(8'h5A, 1'b0, 1'b0);
        cyc = 0;
        while (rdn === 1'b1 && cyc < 50) begin tick(); cyc++; end
        cyc = 0;
        while (rdn === 1'b0 && cyc < 20) begin tick(); cyc++; end
        cyc = 0;
        while (hs_fault !== 1'b1 && cyc < 100) begin tick(); cyc++; end
        check("t4_fault_delay", cyc, 32);
        exp_q.push_back('{data: 8'h5A, perr: 1'b0, ferr: 1'b0});
        cyc = 0;
        while (rdn === 1'b1 && cyc < 10) begin tick(); cyc++; end
        check("t4_second_strobe", int'(rdn), 0);
        cyc = 0;
        while (rdn === 1'b0 && cyc < 20) begin tick(); cyc++; end
        r_ready = 1'b0;
        tick(6);
        check("t4_fault_sticky", int'(hs_fault), 1);
        drain("t4");

        // 5: continuous consumer keeps occupancy at one
        do_reset();
        out_ready = 1'b1;
        max_level = 0;
        track_level = 1'b1;
        for (int i = 0; i < 5; i++) begin
            present(bytes5[i], 1'b0, 1'b0);
            finish_read("t5");
        end
        drain("t5");
        track_level = 1'b0;
        check("t5_max_level", max_level, 1);

        // 6: reset while the strobe is low
        do_reset();
        present(8'h81, 1'b1, 1'b1);
        finish_read("t6a");
        check("t6_pre_level", int'(fifo_level), 1);
        check("t6_pre_perr_cnt", int'(perr_count), 1);
        present(8'h42, 1'b0, 1'b0);
        cyc = 0;
        while (rdn === 1'b1 && cyc < 50) begin tick(); cyc++; end
        clr = 1'b1;
        tick();
        check("t6_rdn", int'(rdn), 1);
        check("t6_level", int'(fifo_level), 0);
        check("t6_perr_cnt", int'(perr_count), 0);
        check("t6_ferr_cnt", int'(ferr_count), 0);
        clr = 1'b0;
        r_ready = 1'b0;
        exp_q.delete();
        tick(8);
        check("t6_level_after", int'(fifo_level), 0);
        check("t6_valid_after", int'(out_valid), 0);

        check("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1);
    end

endmodule
